// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the MEM/LSU stage: memory op codes,
//               exception codes, FSM states and op-decoding helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [1:0] EXCP_NONE     = 2'd0;
    localparam logic [1:0] EXCP_MISALIGN = 2'd1;
    localparam logic [1:0] EXCP_BUS_ERR  = 2'd2;
    localparam logic [1:0] EXCP_TIMEOUT  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SIZE_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: return SIZE_HALF;
            MEM_LW, MEM_SW:          return SIZE_WORD;
            default:                 return SIZE_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_steer
// Description : Combinational byte-lane steering: byte enables, replicated
//               store data, extended load data and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_steer
    import mem_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [1:0]  w_size;
    logic [1:0]  w_byte_lane;
    logic        w_half_upper;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Map the address offset onto physical lanes and pick the addressed data
    always_comb begin
        w_size       = op_size(op);
        // Big-endian offset k lives in lane 3-k, which for 2 bits is ~k
        w_byte_lane  = (BIG_ENDIAN != 0) ? ~offset : offset;
        w_half_upper = (BIG_ENDIAN != 0) ? ~offset[1] : offset[1];
        w_byte       = rdata[8*w_byte_lane +: 8];
        w_half       = w_half_upper ? rdata[31:16] : rdata[15:0];

        sel        = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        case (w_size)
            SIZE_BYTE: begin
                sel   = 4'b0001 << w_byte_lane;
                wdata = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                sel        = w_half_upper ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            SIZE_WORD: begin
                sel        = 4'b1111;
                wdata      = store_data;
                misaligned = (offset != 2'b00);
            end
            default: ;
        endcase

        case (op)
            MEM_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: load_data = {24'h0, w_byte};
            MEM_LH:  load_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: load_data = {16'h0, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_stage
// Description : Pipeline MEM stage with a req/ack load/store unit. Passes
//               write-back and HI/LO through, stalls while a bus transfer is
//               outstanding, flags misalignment, bus errors and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_stage
    import mem_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 16,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    input  logic [3:0]            memop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           store_data_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [31:0]           bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    input  logic [31:0]           bus_rdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o,
    output logic                  excp_o,
    output logic [1:0]            excp_code_o
);

    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               C_TMO_EN   = (TIMEOUT != 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic             r_tmo;

    logic             w_is_mem;
    logic [3:0]       w_sel;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;
    logic             w_misaligned;

    assign w_is_mem = (memop_i != MEM_NOP);

    mem_lane_steer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_steer (
        .op         (memop_i),
        .offset     (mem_addr_i[1:0]),
        .store_data (store_data_i),
        .rdata      (r_rdata),
        .sel        (w_sel),
        .wdata      (w_wdata),
        .load_data  (w_load_data),
        .misaligned (w_misaligned)
    );

    // Transfer sequencing: launch, wait for ack or timeout, one result cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mem && !w_misaligned) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_tmo   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack_i) begin
                        r_rdata <= bus_rdata_i;
                        r_err   <= bus_err_i;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (C_TMO_EN && (r_cnt == C_CNT_LAST)) begin
                            r_tmo   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output decode: pass-through by default, bus drive in WAIT, results in DONE
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        whilo_o     = whilo_i;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'h0;
        bus_sel_o   = 4'b0000;
        bus_wdata_o = 32'h0;
        stallreq_o  = 1'b0;
        excp_o      = 1'b0;
        excp_code_o = EXCP_NONE;

        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    // Memory ops never write back until their result cycle
                    wreg_o  = 1'b0;
                    whilo_o = 1'b0;
                    if (w_misaligned) begin
                        excp_o      = 1'b1;
                        excp_code_o = EXCP_MISALIGN;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                bus_req_o   = 1'b1;
                bus_we_o    = is_store(memop_i);
                bus_addr_o  = {mem_addr_i[31:2], 2'b00};
                bus_sel_o   = w_sel;
                bus_wdata_o = w_wdata;
                stallreq_o  = 1'b1;
                wreg_o      = 1'b0;
                whilo_o     = 1'b0;
            end
            ST_DONE: begin
                if (is_load(memop_i)) begin
                    wdata_o = w_load_data;
                end
                if (r_err || r_tmo) begin
                    excp_o      = 1'b1;
                    excp_code_o = r_err ? EXCP_BUS_ERR : EXCP_TIMEOUT;
                    wreg_o      = 1'b0;
                    whilo_o     = 1'b0;
                end
            end
            default: ;
        endcase

        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = 32'h0;
            hi_o        = 32'h0;
            lo_o        = 32'h0;
            whilo_o     = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = 32'h0;
            bus_sel_o   = 4'b0000;
            bus_wdata_o = 32'h0;
            stallreq_o  = 1'b0;
            excp_o      = 1'b0;
            excp_code_o = EXCP_NONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu_stage
// Description : Directed self-checking bench for mem_lsu_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        whilo_i;
    logic [3:0]  memop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;
    logic        excp_o;
    logic [1:0]  excp_code_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu_stage #(
        .REG_ADDR_W (5),
        .TIMEOUT    (16),
        .BIG_ENDIAN (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .whilo_i      (whilo_i),
        .memop_i      (memop_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_sel_o    (bus_sel_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_err_i    (bus_err_i),
        .bus_rdata_i  (bus_rdata_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .whilo_o      (whilo_o),
        .stallreq_o   (stallreq_o),
        .excp_o       (excp_o),
        .excp_code_o  (excp_code_o)
    );

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata);
        memop_i      = op;
        mem_addr_i   = addr;
        store_data_i = sdata;
        bus_ack_i    = 1'b0;
        bus_err_i    = 1'b0;
    endtask

    task automatic set_nop();
        set_op(MEM_NOP, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEADBEEF;
        hi_i = 32'h1111; lo_i = 32'h2222; whilo_i = 1'b1;
        set_nop();
        next_cycle();
        next_cycle();
        #1;
        checks++; if (wd_o !== 5'd0) begin failures++; $display("FAIL reset_wd got %0d want 0", wd_o); end
        checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL reset_wreg got %b want 0", wreg_o); end
        checks++; if (wdata_o !== 32'h0) begin failures++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
        checks++; if (whilo_o !== 1'b0) begin failures++; $display("FAIL reset_whilo got %b want 0", whilo_o); end
        checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL reset_stall_req got %b/%b want 0/0", stallreq_o, bus_req_o); end
        rst = 1'b0;
    endtask

    task automatic test_nop();
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
        hi_i = 32'hCAFE0001; lo_i = 32'hCAFE0002; whilo_i = 1'b1;
        set_nop();
        #1;
        checks++; if (wd_o !== 5'd3) begin failures++; $display("FAIL nop_wd got %0d want 3", wd_o); end
        checks++; if (wreg_o !== 1'b1) begin failures++; $display("FAIL nop_wreg got %b want 1", wreg_o); end
        checks++; if (wdata_o !== 32'h1234) begin failures++; $display("FAIL nop_wdata got %h want 00001234", wdata_o); end
        checks++; if (hi_o !== 32'hCAFE0001 || lo_o !== 32'hCAFE0002) begin failures++; $display("FAIL nop_hilo got %h/%h want cafe0001/cafe0002", hi_o, lo_o); end
        checks++; if (whilo_o !== 1'b1) begin failures++; $display("FAIL nop_whilo got %b want 1", whilo_o); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL nop_no_bus cycle %0d got stall=%b req=%b want 0/0", i, stallreq_o, bus_req_o); end
            next_cycle();
        end
    endtask

    task automatic test_load(input logic [3:0] op, input logic [31:0] exp, input string name);
        wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h77; whilo_i = 1'b0;
        set_op(op, 32'h101, 32'h0);
        bus_rdata_i = 32'h00F00000;
        #1;
        checks++; if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin failures++; $display("FAIL %s_idle got stall=%b req=%b want 1/0", name, stallreq_o, bus_req_o); end
        next_cycle();
        checks++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || stallreq_o !== 1'b1) begin failures++; $display("FAIL %s_wait_ctl got req=%b we=%b stall=%b want 1/0/1", name, bus_req_o, bus_we_o, stallreq_o); end
        checks++; if (bus_sel_o !== 4'b0100 || bus_addr_o !== 32'h100) begin failures++; $display("FAIL %s_wait_bus got sel=%b addr=%h want 0100/00000100", name, bus_sel_o, bus_addr_o); end
        bus_ack_i = 1'b1;
        next_cycle();
        bus_ack_i = 1'b0;
        #1;
        checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL %s_done_ctl got stall=%b req=%b want 0/0", name, stallreq_o, bus_req_o); end
        checks++; if (wdata_o !== exp) begin failures++; $display("FAIL %s_done_wdata got %h want %h", name, wdata_o, exp); end
        checks++; if (wreg_o !== 1'b1 || excp_o !== 1'b0) begin failures++; $display("FAIL %s_done_wb got wreg=%b excp=%b want 1/0", name, wreg_o, excp_o); end
        next_cycle();
        set_nop();
    endtask

    task automatic test_store_sh();
        wd_i = 5'd6; wreg_i = 1'b0; wdata_i = 32'h0BAD; whilo_i = 1'b0;
        set_op(MEM_SH, 32'h202, 32'hAAAA5678);
        #1;
        checks++; if (stallreq_o !== 1'b1) begin failures++; $display("FAIL sh_idle_stall got %b want 1", stallreq_o); end
        next_cycle();
        checks++; if (bus_addr_o !== 32'h200) begin failures++; $display("FAIL sh_addr got %h want 00000200", bus_addr_o); end
        checks++; if (bus_sel_o !== 4'b0011) begin failures++; $display("FAIL sh_sel got %b want 0011", bus_sel_o); end
        checks++; if (bus_wdata_o !== 32'h56785678) begin failures++; $display("FAIL sh_wdata got %h want 56785678", bus_wdata_o); end
        checks++; if (bus_we_o !== 1'b1 || bus_req_o !== 1'b1) begin failures++; $display("FAIL sh_we_req got we=%b req=%b want 1/1", bus_we_o, bus_req_o); end
        bus_ack_i = 1'b1;
        next_cycle();
        bus_ack_i = 1'b0;
        #1;
        checks++; if (wdata_o !== 32'h0BAD || excp_o !== 1'b0 || stallreq_o !== 1'b0) begin failures++; $display("FAIL sh_done got wdata=%h excp=%b stall=%b want 00000bad/0/0", wdata_o, excp_o, stallreq_o); end
        next_cycle();
        set_nop();
    endtask

    task automatic test_misaligned();
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1; whilo_i = 1'b1;
        set_op(MEM_LW, 32'h3, 32'h0);
        #1;
        checks++; if (excp_o !== 1'b1 || excp_code_o !== 2'd1) begin failures++; $display("FAIL lw_misalign_excp got excp=%b code=%0d want 1/1", excp_o, excp_code_o); end
        checks++; if (wreg_o !== 1'b0 || whilo_o !== 1'b0) begin failures++; $display("FAIL lw_misalign_wb got wreg=%b whilo=%b want 0/0", wreg_o, whilo_o); end
        checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL lw_misalign_bus got stall=%b req=%b want 0/0", stallreq_o, bus_req_o); end
        next_cycle();
        checks++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin failures++; $display("FAIL lw_misalign_stays_idle got req=%b stall=%b want 0/0", bus_req_o, stallreq_o); end
        set_op(MEM_LH, 32'h201, 32'h0);
        #1;
        checks++; if (excp_o !== 1'b1 || excp_code_o !== 2'd1 || stallreq_o !== 1'b0) begin failures++; $display("FAIL lh_misalign got excp=%b code=%0d stall=%b want 1/1/0", excp_o, excp_code_o, stallreq_o); end
        next_cycle();
        set_nop();
    endtask

    task automatic test_timeout();
        int waits;
        wd_i = 5'd8; wreg_i = 1'b1; wdata_i = 32'h0; whilo_i = 1'b0;
        set_op(MEM_LW, 32'h10, 32'h0);
        next_cycle();
        waits = 0;
        while (bus_req_o === 1'b1 && waits < 40) begin
            waits++;
            next_cycle();
        end
        checks++; if (waits !== 16) begin failures++; $display("FAIL timeout_wait_cycles got %0d want 16", waits); end
        checks++; if (excp_o !== 1'b1 || excp_code_o !== 2'd3) begin failures++; $display("FAIL timeout_excp got excp=%b code=%0d want 1/3", excp_o, excp_code_o); end
        checks++; if (wreg_o !== 1'b0 || stallreq_o !== 1'b0) begin failures++; $display("FAIL timeout_wb got wreg=%b stall=%b want 0/0", wreg_o, stallreq_o); end
        next_cycle();
        set_nop();
    endtask

    task automatic test_bus_err();
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0; whilo_i = 1'b1;
        set_op(MEM_LW, 32'h20, 32'h0);
        next_cycle();
        bus_err_i = 1'b1;
        next_cycle();
        checks++; if (bus_req_o !== 1'b1 || excp_o !== 1'b0) begin failures++; $display("FAIL err_without_ack got req=%b excp=%b want 1/0", bus_req_o, excp_o); end
        bus_ack_i = 1'b1;
        bus_err_i = 1'b1;
        next_cycle();
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        #1;
        checks++; if (excp_o !== 1'b1 || excp_code_o !== 2'd2) begin failures++; $display("FAIL bus_err_excp got excp=%b code=%0d want 1/2", excp_o, excp_code_o); end
        checks++; if (wreg_o !== 1'b0 || whilo_o !== 1'b0) begin failures++; $display("FAIL bus_err_wb got wreg=%b whilo=%b want 0/0", wreg_o, whilo_o); end
        next_cycle();
        set_nop();
    endtask

    task automatic test_reset_in_wait();
        wd_i = 5'd10; wreg_i = 1'b1; wdata_i = 32'h0; whilo_i = 1'b0;
        set_op(MEM_LW, 32'h30, 32'h0);
        next_cycle();
        checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL rstwait_in_wait got req=%b want 1", bus_req_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b0 || excp_o !== 1'b0) begin failures++; $display("FAIL rstwait_forced got req=%b stall=%b excp=%b want 0/0/0", bus_req_o, stallreq_o, excp_o); end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++; if (bus_req_o !== 1'b0 || stallreq_o !== 1'b1) begin failures++; $display("FAIL rstwait_idle got req=%b stall=%b want 0/1", bus_req_o, stallreq_o); end
        set_nop();
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h55AA;
        #1;
        checks++; if (wdata_o !== 32'h55AA || wd_o !== 5'd7 || wreg_o !== 1'b1 || stallreq_o !== 1'b0) begin failures++; $display("FAIL rstwait_nop got wdata=%h wd=%0d wreg=%b stall=%b want 000055aa/7/1/0", wdata_o, wd_o, wreg_o, stallreq_o); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; hi_i = '0; lo_i = '0; whilo_i = 1'b0;
        bus_rdata_i = '0;
        set_nop();
        test_reset();
        test_nop();
        test_load(MEM_LB, 32'hFFFFFFF0, "lb");
        test_load(MEM_LBU, 32'h000000F0, "lbu");
        test_store_sh();
        test_misaligned();
        test_timeout();
        test_bus_err();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
